latch_strobe_tx: RTL

LATCH_STROBE_TX -- requirements
Module: latch_strobe_tx

---
 rtl/latch_tx_pkg.sv | 24 ++
 rtl/phase_timer.sv | 33 +++
 rtl/latch_strobe_tx.sv | 115 +++++++++++
 3 files changed

// File: rtl/latch_tx_pkg.sv
// Shared definitions for the latch strobe transmitter: state encoding,
// default timing constants and a small sizing helper.
package latch_tx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StGate  = 2'd2,
        StHold  = 2'd3
    } state_e;

    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefSetupCyc = 2;
    localparam int unsigned DefGateCyc  = 3;
    localparam int unsigned DefHoldCyc  = 1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with a zero flag; times each transfer phase.
module phase_timer #(
    parameter int unsigned CntW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    output logic            zero_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/latch_strobe_tx.sv
// Drives a data bus and a gate strobe for downstream level-sensitive latches,
// sequencing setup, transparent window and hold for each accepted word.
module latch_strobe_tx
    import latch_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned SETUP_CYC = DefSetupCyc,
    parameter int unsigned GATE_CYC  = DefGateCyc,
    parameter int unsigned HOLD_CYC  = DefHoldCyc
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             gate,
    output logic             busy,
    output logic             done,
    output logic [15:0]      xfer_cnt
);

    localparam int unsigned MaxCyc = max3(SETUP_CYC, GATE_CYC, HOLD_CYC);
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    // Timer is loaded with N-1 so a phase spans exactly N cycles.
    localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] GateLd  = CntW'(GATE_CYC - 1);
    localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [15:0]      xfer_cnt_q, xfer_cnt_d;
    logic             gate_q, gate_d;
    logic             done_q, done_d;
    logic             tmr_load;
    logic [CntW-1:0]  tmr_load_val;
    logic             tmr_zero;

    phase_timer #(
        .CntW(CntW)
    ) u_phase_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_load_val),
        .zero_o    (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        xfer_cnt_d   = xfer_cnt_q;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d      = StSetup;
                    out_data_d   = in_data;
                    tmr_load     = 1'b1;
                    tmr_load_val = SetupLd;
                end
            end
            StSetup: begin
                if (tmr_zero) begin
                    state_d      = StGate;
                    tmr_load     = 1'b1;
                    tmr_load_val = GateLd;
                end
            end
            StGate: begin
                if (tmr_zero) begin
                    state_d      = StHold;
                    tmr_load     = 1'b1;
                    tmr_load_val = HoldLd;
                end
            end
            StHold: begin
                if (tmr_zero) begin
                    state_d    = StIdle;
                    done_d     = 1'b1;
                    xfer_cnt_d = xfer_cnt_q + 16'd1;
                end
            end
        endcase
        // Gate is registered from the next state so it toggles on the phase edge itself.
        gate_d = (state_d == StGate);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            out_data_q <= '0;
            xfer_cnt_q <= '0;
            gate_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            xfer_cnt_q <= xfer_cnt_d;
            gate_q     <= gate_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign out_data = out_data_q;
    assign gate     = gate_q;
    assign done     = done_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule
